// File: rtl/ysyx_22040759_imem_pkg.sv
// Shared definitions for the instruction-memory responder.
//   IMEM_NOP_INST  : instruction returned when no valid data is available
//   IMEM_BASE_ADDR : default byte address of doubleword 0
//   imem_state_e   : responder FSM encoding (IDLE / LOAD / RUN)
package ysyx_22040759_imem_pkg;

    localparam logic [31:0] IMEM_NOP_INST  = 32'h0000_0013;
    localparam logic [63:0] IMEM_BASE_ADDR = 64'h0000_0000_8000_0000;

    typedef enum logic [1:0] {
        IMEM_IDLE = 2'd0,
        IMEM_LOAD = 2'd1,
        IMEM_RUN  = 2'd2
    } imem_state_e;

endpackage

// File: rtl/ysyx_22040759_imem_array.sv
// Single-port 64-bit RAM, 2^DEPTH_LOG2 doublewords, synchronous read and write.
//   clk   : clock
//   en    : port enable (read or write this cycle)
//   we    : write enable (when en); otherwise a read is performed
//   addr  : doubleword address
//   wdata : write data
//   rdata : read data, registered; holds when no read is performed
module ysyx_22040759_imem_array #(
    parameter int DEPTH_LOG2 = 12
) (
    input  logic                  clk,
    input  logic                  en,
    input  logic                  we,
    input  logic [DEPTH_LOG2-1:0] addr,
    input  logic [63:0]           wdata,
    output logic [63:0]           rdata
);

    logic [63:0] mem [2**DEPTH_LOG2];

    // NOTE: the array and its read register carry no reset so the tools can map them onto block RAM.
    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                mem[addr] <= wdata;
            end else begin
                rdata <= mem[addr];
            end
        end
    end

endmodule

// File: rtl/ysyx_22040759_imem_resp.sv
// Instruction-memory responder for the fetch port.
// Loads a program image from a byte-serial stream, then answers fetch requests
// with a 32-bit instruction one cycle later.
//   clk, rst          : clock, asynchronous active-low reset
//   i_ram_en          : fetch request strobe
//   inst_raddr        : fetch byte address
//   inst, inst_err    : fetched instruction and its error flag
//   ld_start          : (re)enter LOAD, clear write pointer
//   ld_valid/ld_ready : load byte handshake
//   ld_byte, ld_last  : program byte (little-endian) and end-of-image marker
//   ld_err            : sticky overflow flag
//   busy              : high while not in RUN; core holds its PC
module ysyx_22040759_imem_resp
    import ysyx_22040759_imem_pkg::*;
#(
    parameter int          DEPTH_LOG2 = 12,
    parameter logic [63:0] BASE_ADDR  = IMEM_BASE_ADDR,  // must be 4-byte aligned
    parameter logic [31:0] NOP_INST   = IMEM_NOP_INST
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_ram_en,
    input  logic [63:0] inst_raddr,
    output logic [31:0] inst,
    output logic        inst_err,
    input  logic        ld_start,
    input  logic        ld_valid,
    output logic        ld_ready,
    input  logic [7:0]  ld_byte,
    input  logic        ld_last,
    output logic        ld_err,
    output logic        busy
);

    imem_state_e state, next_state;

    logic [DEPTH_LOG2:0] wptr;     // top bit set means the array is full
    logic [2:0]          bcnt;
    logic [63:0]         asm_q;
    logic [63:0]         merged;
    logic                ld_fire;
    logic                full;
    logic                word_done;

    logic [63:2]         off;
    logic                fetch_go;
    logic                fetch_err;

    logic                nop_q;
    logic                err_q;
    logic                lane_q;

    logic                arr_en;
    logic [DEPTH_LOG2-1:0] arr_addr;
    logic [63:0]         arr_rdata;

    assign ld_ready = (state == IMEM_LOAD);
    assign busy     = (state != IMEM_RUN);

    // ld_start wins over a byte offered in the same cycle; that byte is dropped.
    assign ld_fire   = ld_ready && ld_valid && !ld_start;
    assign full      = wptr[DEPTH_LOG2];
    assign word_done = ld_fire && !full && ((bcnt == 3'd7) || ld_last);

    // Lanes above bcnt are still zero, so a short final word is zero-padded.
    always_comb begin
        merged = asm_q;
        for (int i = 0; i < 8; i++) begin
            if (bcnt == 3'(i)) begin
                merged[8*i +: 8] = ld_byte;
            end
        end
    end

    // Base is word aligned, so the two low offset bits never matter.
    assign off       = inst_raddr[63:2] - BASE_ADDR[63:2];
    assign fetch_go  = (state == IMEM_RUN) && i_ram_en;
    assign fetch_err = (|inst_raddr[1:0]) || (inst_raddr < BASE_ADDR)
                     || (|off[63:DEPTH_LOG2+3]);

    // Writes happen only in LOAD and reads only in RUN, so one port suffices.
    assign arr_en   = word_done || fetch_go;
    assign arr_addr = (state == IMEM_LOAD) ? wptr[DEPTH_LOG2-1:0] : off[DEPTH_LOG2+2:3];

    ysyx_22040759_imem_array #(
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_array (
        .clk   (clk),
        .en    (arr_en),
        .we    (word_done),
        .addr  (arr_addr),
        .wdata (merged),
        .rdata (arr_rdata)
    );

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IMEM_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // NOTE: next_state gets its default first, so no path through the case can infer a latch.
    always_comb begin
        next_state = state;
        case (state)
            IMEM_IDLE: if (ld_start) next_state = IMEM_LOAD;
            IMEM_LOAD: begin
                if (ld_start) begin
                    next_state = IMEM_LOAD;
                end else if (ld_fire && ld_last) begin
                    next_state = IMEM_RUN;
                end
            end
            IMEM_RUN:  if (ld_start) next_state = IMEM_LOAD;
            default:   next_state = IMEM_IDLE;
        endcase
    end

    // Byte assembler and write pointer.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wptr   <= '0;
            bcnt   <= '0;
            asm_q  <= '0;
            ld_err <= 1'b0;
        end else if (ld_start) begin
            wptr   <= '0;
            bcnt   <= '0;
            asm_q  <= '0;
            ld_err <= 1'b0;
        end else if (ld_fire) begin
            if (full) begin
                ld_err <= 1'b1;
            end else if (word_done) begin
                wptr  <= wptr + 1'b1;
                bcnt  <= '0;
                asm_q <= '0;
            end else begin
                asm_q <= merged;
                bcnt  <= bcnt + 3'd1;
            end
        end
    end

    // Fetch response qualifiers. Keyed on next_state so the output shows NOP
    // in the very first cycle after RUN is left.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            nop_q  <= 1'b1;
            err_q  <= 1'b0;
            lane_q <= 1'b0;
        end else if (next_state != IMEM_RUN) begin
            nop_q  <= 1'b1;
            err_q  <= 1'b0;
        end else if (fetch_go) begin
            nop_q  <= 1'b0;
            err_q  <= fetch_err;
            lane_q <= off[2];
        end
    end

    assign inst     = (nop_q || err_q) ? NOP_INST
                    : (lane_q ? arr_rdata[63:32] : arr_rdata[31:0]);
    assign inst_err = err_q;

endmodule
